varint_encode_fsm: RTL and testbench
====================================

# varint_encode_fsm

Upstream producer for the output-ordering stage. It accepts 64-bit field values tagged with a 10-bit output index and serializes each value into protobuf varint bytes: 7 payload bits per byte, LSB group first, bit 7 set on every byte except the last. Optionally, it applies zigzag encoding for signed fields. It presents one byte at a time, with its index, on the valid/accepted handshake that the ordering FSM consumes.

## Interface
- No parameters. Widths are fixed: value 64, index 10, byte 8.
- `clk  in  1`  Single clock; all state updates on the rising edge.
- `reset  in  1`  Asynchronous, active-low. Asserting it (0) clears all state immediately.
- `in_valid  in  1`  Upstream value is present.
- `in_ready  out  1`  Block can take a value this cycle.
- `in_value  in  64`  Raw field value.
- `in_index  in  10`  Output index tag for every byte of this value.
- `in_zigzag  in  1`  1 = treat `in_value` as signed and zigzag-encode it.
- `varint_data  out  8`  Current encoded byte (registered).
- `varint_out_index_q  out  10`  Index tag of the current byte (registered).
- `varint_data_valid  out  1`  Current byte is valid.
- `varint_last  out  1`  Current byte is the final byte of its value.
- `varint_data_accepted  in  1`  Single-cycle pulse. The consumer takes the current byte at this clock edge.
- `values_done  out  16`  Count of fully emitted values; wraps from 0xFFFF to 0.

## Operation
- **Reset values:** `in_ready`=0 while reset is asserted. `varint_data`=0x00, `varint_out_index_q`=0, `varint_data_valid`=0, `varint_last`=0, `values_done`=0. State is IDLE.
- **State IDLE**
  - `in_ready`=1 and `varint_data_valid`=0.
  - On `in_valid`&`in_ready`: latch `in_index`.
  - Load the remainder register `rem` with `in_value`. If `in_zigzag`=1, load `(in_value<<1) ^ {64{in_value[63]}}` instead.
  - Transition to EMIT.
- **State EMIT**
  - `varint_data_valid`=1.
  - `varint_data` = `{rem[63:7]!=0, rem[6:0]}`.
  - `varint_last` = `(rem[63:7]==0)`.
  - `varint_out_index_q` = the latched index.
  - On `varint_data_accepted` with not last: `rem <= rem>>7`; stay in EMIT.
  - On `varint_data_accepted` with last: increment `values_done`.
    - If `in_valid` is also high, load the next value as in IDLE and stay in EMIT.
    - Otherwise go to IDLE.
- `in_ready` = IDLE, or (EMIT & `varint_data_accepted` & `varint_last`). This term is combinational on `varint_data_accepted`.
- Outputs are driven from registers: byte, index, valid, and last are all decoded from registered `rem`, state, and index. On the accept edge, the next byte or the deasserted valid is therefore visible in the following cycle. The consumer must never see a stale byte in the cycle after an accept.
- **Byte count per value:** 1 to 10.
  - Value 0 emits a single 0x00.
  - Values of 2^63 and above emit 10 bytes; the tenth byte is 0x01.
  - A 4-bit byte counter tracks position. If the counter reaches 10 while `rem`≠0, that is a design error; flag it with a simulation assertion only.
- `varint_data_accepted` while `varint_data_valid`=0 is ignored.
- `in_value` and `in_zigzag` are sampled only at the load edge. Later changes do not affect a value in flight.

## Timing
- **Latency:** value accepted at edge N → first byte valid in cycle N+1.
- **Throughput:** one byte per cycle when the consumer accepts every cycle.
- **Back-to-back values:** zero bubbles. The last byte of value k and the first byte of value k+1 are in consecutive cycles if the consumer accepts.
- **Stall:** while `varint_data_accepted`=0, all outputs hold stable indefinitely.
- **Reset mid-value:**
  - Asynchronous clear. `varint_data_valid` drops in the same cycle.
  - The partial value is discarded and `values_done` is cleared.
  - After release, the first edge with `in_valid` loads a fresh value.
- **`values_done` wrap:** the increment at 0xFFFF yields 0x0000 with no flag.

## Test plan
- **Basic encoding:** `in_value`=300, `in_index`=5, `in_zigzag`=0, accept every cycle.
  - Bytes 0xAC (last=0), then 0x02 (last=1), both with index 5.
  - `values_done`=1. Byte 0 valid exactly one cycle after the load edge.
- **Zero and maximum values:**
  - `in_value`=0 → single byte 0x00 with last=1.
  - `in_value`=0xFFFF_FFFF_FFFF_FFFF → nine bytes 0xFF, then 0x01 with last=1.
- **Zigzag:** `in_zigzag`=1 with values -1, 1, -2, 0x7FFF_FFFF_FFFF_FFFF.
  - Single bytes 0x01, 0x02, 0x03 for the first three.
  - The last value emits 0xFE, then eight bytes 0xFF, then 0x01.
- **Back-to-back and stall:**
  - Back-to-back: values 1 (index 3) and 128 (index 4) presented with `in_valid` held high.
    - Bytes 0x01/idx3, 0x80/idx4, 0x01/idx4 in three consecutive cycles.
    - `in_ready` pulses during the last-byte accept.
  - Stall: repeat with `varint_data_accepted` held low for 5 cycles mid-value. Outputs must stay unchanged, with no byte lost or duplicated.
- **Reset mid-value:** pull `reset` low during byte 2 of a 10-byte value.
  - Valid drops in the same cycle.
  - All outputs return to their reset values, and `values_done`=0.
  - After release, value 5 emits a single 0x05.

Source files
------------

// File: rtl/varint_encode_fsm.sv
// Protobuf varint serializer: takes 64-bit values (optionally zigzag-encoded) and
// emits them one byte at a time, LSB group first, tagged with an output index.
module varint_encode_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [9:0]  in_index,
    input  logic        in_zigzag,
    output logic [7:0]  varint_data,
    output logic [9:0]  varint_out_index_q,
    output logic        varint_data_valid,
    output logic        varint_last,
    input  logic        varint_data_accepted,
    output logic [15:0] values_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_rem;
    logic [9:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_done;

    logic        w_emit;
    logic        w_more;
    logic        w_accept;
    logic        w_final;
    logic        w_load;
    logic [63:0] w_load_val;

    function automatic logic [63:0] zigzag64(input logic [63:0] v);
        return (v << 1) ^ {64{v[63]}};
    endfunction

    assign w_emit     = (r_state == S_EMIT);
    assign w_more     = |r_rem[63:7];
    assign w_accept   = w_emit & varint_data_accepted;
    assign w_final    = w_accept & ~w_more;
    assign w_load     = in_valid & in_ready;
    assign w_load_val = in_zigzag ? zigzag64(in_value) : in_value;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a final-byte accept with a new value waiting stays in EMIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_final && !in_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode straight from registered state so the byte after an accept is never stale
    always_comb begin
        in_ready           = reset & (~w_emit | w_final);
        varint_data_valid  = w_emit;
        varint_data        = 8'h00;
        varint_last        = 1'b0;
        varint_out_index_q = r_idx;
        values_done        = r_done;
        if (w_emit) begin
            varint_data = {w_more, r_rem[6:0]};
            varint_last = ~w_more;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= 64'd0;
            r_idx  <= 10'd0;
            r_cnt  <= 4'd0;
            r_done <= 16'd0;
        end else begin
            if (w_load) begin
                r_rem <= w_load_val;
                r_idx <= in_index;
                r_cnt <= 4'd0;
            end else if (w_accept && w_more) begin
                r_rem <= r_rem >> 7;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_final) begin
                r_done <= r_done + 16'd1;
            end
        end
    end

    // A 64-bit value never needs more than ten bytes
    always @(posedge clk) begin
        if (reset && w_emit) begin
            assert (!((r_cnt == 4'd10) && w_more));
        end
    end

endmodule

// File: tb/tb_varint_encode_fsm.sv
// Directed self-checking bench for varint_encode_fsm.
module tb_varint_encode_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [9:0]  in_index;
    logic        in_zigzag;
    logic [7:0]  varint_data;
    logic [9:0]  varint_out_index_q;
    logic        varint_data_valid;
    logic        varint_last;
    logic        varint_data_accepted;
    logic [15:0] values_done;

    int checks   = 0;
    int failures = 0;
    logic [15:0] done_exp = 16'd0;

    varint_encode_fsm dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_value             (in_value),
        .in_index             (in_index),
        .in_zigzag            (in_zigzag),
        .varint_data          (varint_data),
        .varint_out_index_q   (varint_out_index_q),
        .varint_data_valid    (varint_data_valid),
        .varint_last          (varint_last),
        .varint_data_accepted (varint_data_accepted),
        .values_done          (values_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] b, input logic l, input logic [9:0] ix);
        chk({tag, "_valid"}, 64'(varint_data_valid), 64'(1'b1));
        chk({tag, "_data"},  64'(varint_data), 64'(b));
        chk({tag, "_last"},  64'(varint_last), 64'(l));
        chk({tag, "_index"}, 64'(varint_out_index_q), 64'(ix));
    endtask

    // Load one value and consume its n bytes with accept held high: b0 first, bm middle, bl last
    task automatic run_value(input string tag, input logic [63:0] v, input logic zz,
                             input logic [9:0] ix, input int n,
                             input logic [7:0] b0, input logic [7:0] bm, input logic [7:0] bl);
        logic [7:0] e;
        in_valid             = 1'b1;
        in_value             = v;
        in_zigzag            = zz;
        in_index             = ix;
        varint_data_accepted = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(in_ready), 64'(1'b1));
        tick();
        in_valid  = 1'b0;
        in_value  = ~v;
        in_zigzag = ~zz;
        for (int i = 0; i < n; i++) begin
            e = (i == 0) ? b0 : ((i == n - 1) ? bl : bm);
            chk_byte(tag, e, (i == n - 1), ix);
            tick();
        end
        done_exp = done_exp + 16'd1;
        chk({tag, "_idle"}, 64'(varint_data_valid), 64'(1'b0));
        chk({tag, "_done"}, 64'(values_done), 64'(done_exp));
    endtask

    initial begin
        reset                = 1'b0;
        in_valid             = 1'b0;
        in_value             = 64'd0;
        in_index             = 10'd0;
        in_zigzag            = 1'b0;
        varint_data_accepted = 1'b0;
        #2;
        chk("rst_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_valid", 64'(varint_data_valid), 64'(1'b0));
        chk("rst_data",  64'(varint_data), 64'h00);
        chk("rst_index", 64'(varint_out_index_q), 64'd0);
        chk("rst_last",  64'(varint_last), 64'(1'b0));
        chk("rst_done",  64'(values_done), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'(1'b1));

        run_value("basic300", 64'd300, 1'b0, 10'd5, 2, 8'hAC, 8'h00, 8'h02);
        run_value("zero", 64'd0, 1'b0, 10'd9, 1, 8'h00, 8'h00, 8'h00);
        run_value("max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd1023, 10, 8'hFF, 8'hFF, 8'h01);
        run_value("zz_m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 10'd11, 1, 8'h01, 8'h00, 8'h01);
        run_value("zz_p1", 64'd1, 1'b1, 10'd12, 1, 8'h02, 8'h00, 8'h02);
        run_value("zz_m2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 10'd13, 1, 8'h03, 8'h00, 8'h03);
        run_value("zz_big", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 10'd14, 10, 8'hFE, 8'hFF, 8'h01);

        // Back-to-back: 1 (idx 3) then 128 (idx 4), in_valid held high
        in_valid             = 1'b1;
        in_value             = 64'd1;
        in_index             = 10'd3;
        in_zigzag            = 1'b0;
        varint_data_accepted = 1'b1;
        tick();
        in_value = 64'd128;
        in_index = 10'd4;
        #1;
        chk_byte("b2b_0", 8'h01, 1'b1, 10'd3);
        chk("b2b_ready_pulse", 64'(in_ready), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        #1;
        chk_byte("b2b_1", 8'h80, 1'b0, 10'd4);
        chk("b2b_ready_low", 64'(in_ready), 64'(1'b0));
        tick();
        chk_byte("b2b_2", 8'h01, 1'b1, 10'd4);
        tick();
        done_exp = done_exp + 16'd2;
        chk("b2b_idle", 64'(varint_data_valid), 64'(1'b0));
        chk("b2b_done", 64'(values_done), 64'(done_exp));

        // Same pair with a five-cycle stall on the 0x80 byte
        in_valid = 1'b1;
        in_value = 64'd1;
        in_index = 10'd3;
        tick();
        in_value = 64'd128;
        in_index = 10'd4;
        chk_byte("st_0", 8'h01, 1'b1, 10'd3);
        tick();
        in_valid             = 1'b0;
        varint_data_accepted = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_byte("st_hold", 8'h80, 1'b0, 10'd4);
            tick();
        end
        chk_byte("st_1", 8'h80, 1'b0, 10'd4);
        varint_data_accepted = 1'b1;
        tick();
        chk_byte("st_2", 8'h01, 1'b1, 10'd4);
        tick();
        done_exp = done_exp + 16'd2;
        chk("st_idle", 64'(varint_data_valid), 64'(1'b0));
        chk("st_done", 64'(values_done), 64'(done_exp));

        // Reset while byte 2 of a ten-byte value is on the output
        in_valid  = 1'b1;
        in_value  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_index  = 10'd77;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk_byte("mid_b2", 8'hFF, 1'b0, 10'd77);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(varint_data_valid), 64'(1'b0));
        chk("mid_rst_data",  64'(varint_data), 64'h00);
        chk("mid_rst_index", 64'(varint_out_index_q), 64'd0);
        chk("mid_rst_last",  64'(varint_last), 64'(1'b0));
        chk("mid_rst_done",  64'(values_done), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'(1'b0));
        tick();
        reset    = 1'b1;
        done_exp = 16'd0;
        run_value("after_rst", 64'd5, 1'b0, 10'd7, 1, 8'h05, 8'h00, 8'h05);

        // values_done wrap: stream single-byte zeros back-to-back
        in_valid             = 1'b1;
        in_value             = 64'd0;
        in_zigzag            = 1'b0;
        in_index             = 10'd2;
        varint_data_accepted = 1'b1;
        tick();
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_zero", 64'(values_done), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("wrap_one", 64'(values_done), 64'd1);
        chk("wrap_idle", 64'(varint_data_valid), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
